// File: rtl/clk_div_n_pkg.sv
// Purpose: shared types, constants and helpers for the divide-by-N strobe generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: divn_state_e FSM encoding, DIVN_MIN smallest legal divisor,
//           divn_ceil_half() used to place the square-wave falling edge.
package clk_div_n_pkg;

    typedef enum logic [1:0] {
        IDLE,   // en low, counter parked at zero
        RUN,    // counting, no divisor waiting
        PEND    // counting, one accepted divisor waits for the period end
    } divn_state_e;

    localparam int unsigned DIVN_MIN = 1;

    // ceil(d/2): for odd divisors the extra count goes to the high half.
    function automatic logic [31:0] divn_ceil_half(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/divn_counter.sv
// Purpose: WIDTH-bit phase counter that wraps after reaching 'last'.
// Latency: count updates one edge after clr/hold; term is combinational.
// Backpressure: none; hold freezes the count, clr forces zero (clr wins).
// Ports: clk, reset (async, active-high), clr, hold, last (terminal value),
//        count (current phase), term (count == last).
module divn_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             hold,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    assign term = (count == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!hold) begin
            count <= term ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_div_n_fsm.sv
// Purpose: run-time programmable divide-by-N tick/square generator (clock enable, no gating).
// Latency: tick/sq/div_ready are combinational from registered state; a divisor
//          offered mid-period applies at the next period boundary.
// Backpressure: div_ready drops while one divisor is pending; div_valid is then
//          stalled (held by the source), never dropped.
// Ports: clk, reset (async, active-high), en, div_valid/div_in/div_ready (divisor
//        handshake), tick, sq, count, div_cur.
// Optional: define CLK_DIV_N_SYNC_CLR_EN to add input sync_clr (synchronous
//        phase restart that also applies any pending divisor).
module clk_div_n_fsm
    import clk_div_n_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_in,
`ifdef CLK_DIV_N_SYNC_CLR_EN
    input  logic             sync_clr,
`endif
    output logic             div_ready,
    output logic             tick,
    output logic             sq,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_cur
);

    divn_state_e      state, state_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic [WIDTH-1:0] div_cur_n;
    logic [WIDTH-1:0] div_fix;
    logic             cnt_clr;
    logic             term;
    logic             running;
    logic             wrap;
    logic             accept;
    logic             clr_req;

`ifdef CLK_DIV_N_SYNC_CLR_EN
    assign clr_req = sync_clr;
`else
    assign clr_req = 1'b0;
`endif

    assign running   = (state != IDLE);
    assign div_ready = (state != PEND);
    assign accept    = div_valid && div_ready;
    assign wrap      = running && term;
    // A zero divisor would make the terminal value underflow; treat it as 1.
    assign div_fix   = (div_in < WIDTH'(DIVN_MIN)) ? WIDTH'(DIVN_MIN) : div_in;

    assign tick = running && (count == '0);
    assign sq   = running && (32'(count) < divn_ceil_half(32'(div_cur)));

    divn_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .hold  (!running),
        .last  (div_cur - WIDTH'(1)),
        .count (count),
        .term  (term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cur <= WIDTH'(DEFAULT_DIV);
            pend    <= '0;
        end else begin
            state   <= state_n;
            div_cur <= div_cur_n;
            pend    <= pend_n;
        end
    end

    // Every divisor change coincides with a count clear, so count never
    // exceeds the terminal value of the divisor in effect.
    always_comb begin
        state_n   = state;
        div_cur_n = div_cur;
        pend_n    = pend;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (accept) div_cur_n = div_fix;
                if (en)     state_n   = RUN;
            end
            RUN: begin
                if (!en) begin
                    cnt_clr = 1'b1;
                    state_n = IDLE;
                    if (accept) div_cur_n = div_fix;
                end else if (wrap || clr_req) begin
                    cnt_clr = 1'b1;
                    if (accept) div_cur_n = div_fix;
                end else if (accept) begin
                    pend_n  = div_fix;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    cnt_clr   = 1'b1;
                    div_cur_n = pend;
                    state_n   = IDLE;
                end else if (wrap || clr_req) begin
                    cnt_clr   = 1'b1;
                    div_cur_n = pend;
                    state_n   = RUN;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_div_n_fsm.sv
// Purpose: self-checking bench for clk_div_n_fsm (directed table, corner sequences, random vs model).
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: div_valid held while div_ready is low, as a real source would.
module tb_clk_div_n_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         div_valid;
    logic [W-1:0] div_in;
    logic         sync_clr;
    logic         div_ready;
    logic         tick;
    logic         sq;
    logic [W-1:0] count;
    logic [W-1:0] div_cur;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_div_n_fsm #(.WIDTH(W), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_valid (div_valid),
        .div_in    (div_in),
`ifdef CLK_DIV_N_SYNC_CLR_EN
        .sync_clr  (sync_clr),
`endif
        .div_ready (div_ready),
        .tick      (tick),
        .sq        (sq),
        .count     (count),
        .div_cur   (div_cur)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: period length, position inside the period, and at most
    // one queued divisor waiting for the period to end.
    int m_div;
    int m_phase;
    bit m_on;
    int m_q[$];

    task automatic model_reset();
        m_div   = 3;
        m_phase = 0;
        m_on    = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit e, input bit v, input int d, input bit sc);
        bit acc;
        int nd;
        bit at_end;
        acc    = v && (m_q.size() == 0);
        nd     = (d == 0) ? 1 : d;
        at_end = m_on && (m_phase == m_div - 1);
        if (!e) begin
            if (acc) m_div = nd;
            else if (m_q.size() != 0) m_div = m_q.pop_front();
            m_phase = 0;
            m_on    = 0;
        end else if (!m_on) begin
            if (acc) m_div = nd;
            m_phase = 0;
            m_on    = 1;
        end else if (sc || at_end) begin
            if (acc) m_div = nd;
            else if (m_q.size() != 0) m_div = m_q.pop_front();
            m_phase = 0;
        end else begin
            if (acc) m_q.push_back(nd);
            m_phase++;
        end
    endtask

    task automatic model_check();
        chk("tick",      int'(tick),      int'(m_on && m_phase == 0));
        chk("sq",        int'(sq),        int'(m_on && (2 * m_phase < m_div)));
        chk("div_ready", int'(div_ready), int'(m_q.size() == 0));
        chk("count",     int'(count),     m_phase);
        chk("div_cur",   int'(div_cur),   m_div);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_in    = '0;
        sync_clr  = 1'b0;
        #2;
        reset     = 1'b0;
    endtask

    // Each row: outputs expected at this falling edge, then inputs to drive.
    typedef struct {
        bit t; bit s; bit r; int c; int d;
        bit en; bit v; int din;
    } vec_t;

    vec_t tbl[26];

    initial begin
        int first_tick;
        int second_tick;
        int nticks;
        int nsq;

        tbl[0]  = '{0,0,1,0,3, 1,0,0};
        tbl[1]  = '{1,1,1,0,3, 1,0,0};
        tbl[2]  = '{0,1,1,1,3, 1,1,5};
        tbl[3]  = '{0,0,0,2,3, 1,0,0};
        tbl[4]  = '{1,1,1,0,5, 1,0,0};
        tbl[5]  = '{0,1,1,1,5, 1,0,0};
        tbl[6]  = '{0,1,1,2,5, 1,0,0};
        tbl[7]  = '{0,0,1,3,5, 1,0,0};
        tbl[8]  = '{0,0,1,4,5, 1,0,0};
        tbl[9]  = '{1,1,1,0,5, 1,1,2};
        tbl[10] = '{0,1,0,1,5, 1,1,7};
        tbl[11] = '{0,1,0,2,5, 1,1,7};
        tbl[12] = '{0,0,0,3,5, 1,1,7};
        tbl[13] = '{0,0,0,4,5, 1,1,7};
        tbl[14] = '{1,1,1,0,2, 1,1,7};
        tbl[15] = '{0,0,0,1,2, 1,0,0};
        tbl[16] = '{1,1,1,0,7, 1,0,0};
        tbl[17] = '{0,1,1,1,7, 0,0,0};
        tbl[18] = '{0,0,1,0,7, 0,0,0};
        tbl[19] = '{0,0,1,0,7, 1,0,0};
        tbl[20] = '{1,1,1,0,7, 1,1,0};
        tbl[21] = '{0,1,0,1,7, 0,0,0};
        tbl[22] = '{0,0,1,0,1, 1,0,0};
        tbl[23] = '{1,1,1,0,1, 1,0,0};
        tbl[24] = '{1,1,1,0,1, 1,1,1};
        tbl[25] = '{1,1,1,0,1, 1,0,0};

        reset     = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_in    = '0;
        sync_clr  = 1'b0;
        #12;
        reset     = 1'b0;

        // Directed table
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d.tick", i),  int'(tick),      int'(tbl[i].t));
            chk($sformatf("tbl%0d.sq", i),    int'(sq),        int'(tbl[i].s));
            chk($sformatf("tbl%0d.ready", i), int'(div_ready), int'(tbl[i].r));
            chk($sformatf("tbl%0d.count", i), int'(count),     tbl[i].c);
            chk($sformatf("tbl%0d.div", i),   int'(div_cur),   tbl[i].d);
            en        = tbl[i].en;
            div_valid = tbl[i].v;
            div_in    = W'(tbl[i].din);
        end

        // Reset while a divisor is pending: the pending value is lost
        @(negedge clk);
        div_valid = 1'b1;
        div_in    = 8'd4;
        @(negedge clk);
        chk("rstpend.div4", int'(div_cur), 4);
        div_in = 8'd9;
        @(negedge clk);
        chk("rstpend.ready_low", int'(div_ready), 0);
        reset = 1'b1;
        #1;
        chk("rstpend.ready", int'(div_ready), 1);
        chk("rstpend.div",   int'(div_cur),   3);
        chk("rstpend.count", int'(count),     0);
        chk("rstpend.tick",  int'(tick),      0);
        chk("rstpend.sq",    int'(sq),        0);
        @(negedge clk);
        reset     = 1'b0;
        div_valid = 1'b0;
        en        = 1'b1;
        @(negedge clk);
        chk("rstpend.first_tick", int'(tick), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstpend.period3", int'(tick), 1);
        chk("rstpend.div_after", int'(div_cur), 3);

        // Widest divisor
        do_reset();
        @(negedge clk);
        div_valid = 1'b1;
        div_in    = 8'd255;
        @(negedge clk);
        div_valid = 1'b0;
        en        = 1'b1;
        first_tick  = -1;
        second_tick = -1;
        nticks      = 0;
        nsq         = 0;
        for (int k = 0; k < 510; k++) begin
            @(negedge clk);
            if (k == 0) chk("div255.div", int'(div_cur), 255);
            if (tick) begin
                if (first_tick < 0) first_tick = k;
                else if (second_tick < 0) second_tick = k;
                nticks++;
            end
            if (sq) nsq++;
        end
        chk("div255.ticks", nticks, 2);
        chk("div255.first", first_tick, 0);
        chk("div255.gap",   second_tick - first_tick, 255);
        chk("div255.sq",    nsq, 256);

`ifdef CLK_DIV_N_SYNC_CLR_EN
        // Synchronous restart mid-period
        do_reset();
        @(negedge clk);
        en        = 1'b1;
        div_valid = 1'b1;
        div_in    = 8'd4;
        @(negedge clk);
        div_valid = 1'b0;
        chk("sclr.start", int'(count), 0);
        chk("sclr.div",   int'(div_cur), 4);
        @(negedge clk);
        @(negedge clk);
        chk("sclr.at2", int'(count), 2);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        chk("sclr.count0", int'(count), 0);
        chk("sclr.tick",   int'(tick),  1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk($sformatf("sclr.cnt%0d", j), int'(count), j % 4);
        end
`endif

        // Random stimulus against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            bit e, v, sc;
            int d;
            @(negedge clk);
            model_check();
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                model_check();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                e  = ($urandom_range(0, 15) != 0);
                v  = ($urandom_range(0, 3) == 0);
                sc = 1'b0;
`ifdef CLK_DIV_N_SYNC_CLR_EN
                sc = ($urandom_range(0, 31) == 0);
`endif
                case ($urandom_range(0, 7))
                    0:       d = 0;
                    1:       d = 1;
                    2:       d = ($urandom_range(0, 3) == 0) ? 255 : 2;
                    default: d = $urandom_range(2, 9);
                endcase
                en        = e;
                div_valid = v;
                div_in    = W'(d);
                sync_clr  = sc;
                @(posedge clk);
                model_step(e, v, d, sc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
